branch_target_buffer: RTL and testbench

//  Fetch-stage next-PC generator paired with the 2-bit direction predictor.

---
 rtl/branch_target_buffer.sv | 89 ++++++++
 tb/tb_branch_target_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency next-PC prediction at fetch,
// plus resolved-branch write-back, mispredict detection and saturating statistics.
module branch_target_buffer #(
    parameter int ENTRIES = 4,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      if_pc_i,
    input  logic             pred_dir_i,
    output logic [31:0]      npc_pred_o,
    output logic             pred_taken_o,
    input  logic             mem_upd_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_taken_i,
    input  logic [31:0]      mem_target_i,
    input  logic             mem_ptaken_i,
    input  logic [31:0]      mem_ptarget_i,
    input  logic             flush_i,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [29:0]        tgt_mem [ENTRIES];

    logic [IDX_W-1:0]   if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [IDX_W-1:0]   mem_idx;
    logic               hit;
    logic               btb_wr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] one;
        one = '0;
        one[0] = (c != '1);
        return c + one;
    endfunction

    assign if_idx  = if_pc_i[IDX_W+1:2];
    assign if_tag  = if_pc_i[31:IDX_W+2];
    assign mem_idx = mem_pc_i[IDX_W+1:2];

    // Lookup: purely combinational, sees contents before any same-cycle write
    assign hit          = valid[if_idx] && (tag_mem[if_idx] == if_tag);
    assign pred_taken_o = hit && pred_dir_i;
    assign npc_pred_o   = pred_taken_o ? {tgt_mem[if_idx], 2'b00} : if_pc_i + 32'd4;

    assign mispredict_o  = mem_upd_i && ((mem_taken_i != mem_ptaken_i) ||
                           (mem_taken_i && (mem_target_i != mem_ptarget_i)));
    assign redirect_pc_o = mem_taken_i ? mem_target_i : mem_pc_i + 32'd4;

    // Only taken branches allocate; direction history lives in the predictor
    assign btb_wr = mem_upd_i && mem_taken_i && !flush_i;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid      <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (flush_i) begin
                valid <= '0;
            end else if (btb_wr) begin
                valid[mem_idx] <= 1'b1;
            end
            if (pred_taken_o) begin
                hit_cnt_o <= sat_inc(hit_cnt_o);
            end
            if (mispredict_o) begin
                miss_cnt_o <= sat_inc(miss_cnt_o);
            end
        end
    end

    // Tag/target arrays carry no reset; valid bits alone decide a hit
    always_ff @(posedge CLK) begin
        if (btb_wr) begin
            tag_mem[mem_idx] <= mem_pc_i[31:IDX_W+2];
            tgt_mem[mem_idx] <= mem_target_i[31:2];
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer: table of lookup/resolve
// cycles with hand-computed results, plus reset and counter-saturation sequences.
module tb_branch_target_buffer;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] if_pc_i;
    logic        pred_dir_i;
    logic [31:0] npc_pred_o;
    logic        pred_taken_o;
    logic        mem_upd_i;
    logic [31:0] mem_pc_i;
    logic        mem_taken_i;
    logic [31:0] mem_target_i;
    logic        mem_ptaken_i;
    logic [31:0] mem_ptarget_i;
    logic        flush_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_target_buffer #(.ENTRIES(4), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .if_pc_i(if_pc_i), .pred_dir_i(pred_dir_i),
        .npc_pred_o(npc_pred_o), .pred_taken_o(pred_taken_o),
        .mem_upd_i(mem_upd_i), .mem_pc_i(mem_pc_i), .mem_taken_i(mem_taken_i),
        .mem_target_i(mem_target_i), .mem_ptaken_i(mem_ptaken_i),
        .mem_ptarget_i(mem_ptarget_i), .flush_i(flush_i),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic        pd;
        logic        upd;
        logic [31:0] mpc;
        logic        mt;
        logic [31:0] mtgt;
        logic        mpt;
        logic [31:0] mptgt;
        logic        fl;
        logic [31:0] e_npc;
        logic        e_pt;
        logic        e_misp;
        logic [31:0] e_red;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [31:0] pc, input logic pd, input logic upd,
                                input logic [31:0] mpc, input logic mt, input logic [31:0] mtgt,
                                input logic mpt, input logic [31:0] mptgt, input logic fl,
                                input logic [31:0] e_npc, input logic e_pt, input logic e_misp,
                                input logic [31:0] e_red);
        vec_t v;
        v.pc = pc; v.pd = pd; v.upd = upd; v.mpc = mpc; v.mt = mt; v.mtgt = mtgt;
        v.mpt = mpt; v.mptgt = mptgt; v.fl = fl;
        v.e_npc = e_npc; v.e_pt = e_pt; v.e_misp = e_misp; v.e_red = e_red;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_pc_i       = v.pc;
        pred_dir_i    = v.pd;
        mem_upd_i     = v.upd;
        mem_pc_i      = v.mpc;
        mem_taken_i   = v.mt;
        mem_target_i  = v.mtgt;
        mem_ptaken_i  = v.mpt;
        mem_ptarget_i = v.mptgt;
        flush_i       = v.fl;
    endtask

    task automatic idle();
        drive(mk(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
                 32'h0, 1'b0, 1'b0, 32'h0));
    endtask

    initial begin
        nRST = 1'b0;
        idle();

        // Reset: lookup still produces PC+4, counters cleared
        @(posedge CLK); #1;
        if_pc_i = 32'h40; pred_dir_i = 1'b1;
        #3;
        chk("rst_npc", npc_pred_o, 32'h44);
        chk("rst_ptaken", {31'b0, pred_taken_o}, 32'h0);
        chk("rst_hit_cnt", {16'b0, hit_cnt_o}, 32'h0);
        chk("rst_miss_cnt", {16'b0, miss_cnt_o}, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        //            pc            pd    upd   mpc           mt    mtgt          mpt   mptgt         fl      e_npc         e_pt  e_misp e_red
        vecs[0]  = mk(32'h40,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h44,       1'b0, 1'b0, 32'h4);
        vecs[1]  = mk(32'h40,       1'b1, 1'b1, 32'h40,       1'b1, 32'h100,      1'b0, 32'h44,       1'b0,   32'h44,       1'b0, 1'b1, 32'h100);
        vecs[2]  = mk(32'h40,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h100,      1'b1, 1'b0, 32'h4);
        vecs[3]  = mk(32'h40,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h44,       1'b0, 1'b0, 32'h4);
        vecs[4]  = mk(32'h80,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h84,       1'b0, 1'b0, 32'h4);
        vecs[5]  = mk(32'h40,       1'b1, 1'b1, 32'h44,       1'b1, 32'h200,      1'b1, 32'h100,      1'b0,   32'h100,      1'b1, 1'b1, 32'h200);
        vecs[6]  = mk(32'h44,       1'b1, 1'b1, 32'h40,       1'b0, 32'h999,      1'b1, 32'h100,      1'b0,   32'h200,      1'b1, 1'b1, 32'h44);
        vecs[7]  = mk(32'h40,       1'b1, 1'b1, 32'h40,       1'b1, 32'h100,      1'b1, 32'h100,      1'b0,   32'h100,      1'b1, 1'b0, 32'h100);
        vecs[8]  = mk(32'h48,       1'b1, 1'b0, 32'h48,       1'b1, 32'h300,      1'b0, 32'h4C,       1'b0,   32'h4C,       1'b0, 1'b0, 32'h300);
        vecs[9]  = mk(32'h40,       1'b1, 1'b1, 32'h48,       1'b1, 32'h400,      1'b0, 32'h4C,       1'b1,   32'h100,      1'b1, 1'b1, 32'h400);
        vecs[10] = mk(32'h40,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h44,       1'b0, 1'b0, 32'h4);
        vecs[11] = mk(32'h44,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h48,       1'b0, 1'b0, 32'h4);
        vecs[12] = mk(32'h48,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h4C,       1'b0, 1'b0, 32'h4);
        vecs[13] = mk(32'hFFFFFFFC, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h0,        1'b0, 1'b0, 32'h0);
        vecs[14] = mk(32'h40,       1'b0, 1'b1, 32'h80,       1'b1, 32'h500,      1'b0, 32'h84,       1'b0,   32'h44,       1'b0, 1'b1, 32'h500);
        vecs[15] = mk(32'h80,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h500,      1'b1, 1'b0, 32'h4);
        vecs[16] = mk(32'h40,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0,   32'h44,       1'b0, 1'b0, 32'h4);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            #3;
            chk($sformatf("v%0d_npc", i), npc_pred_o, vecs[i].e_npc);
            chk($sformatf("v%0d_ptaken", i), {31'b0, pred_taken_o}, {31'b0, vecs[i].e_pt});
            chk($sformatf("v%0d_misp", i), {31'b0, mispredict_o}, {31'b0, vecs[i].e_misp});
            chk($sformatf("v%0d_redirect", i), redirect_pc_o, vecs[i].e_red);
            @(posedge CLK); #1;
        end
        idle();
        chk("tbl_hit_cnt", {16'b0, hit_cnt_o}, 32'd6);
        chk("tbl_miss_cnt", {16'b0, miss_cnt_o}, 32'd5);

        // Reset mid-operation with a concurrent taken update: everything invalid afterwards
        nRST = 1'b0;
        drive(mk(32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,
                 32'h0, 1'b0, 1'b0, 32'h0));
        @(posedge CLK); #1;
        nRST = 1'b1;
        idle();
        chk("midrst_hit_cnt", {16'b0, hit_cnt_o}, 32'h0);
        chk("midrst_miss_cnt", {16'b0, miss_cnt_o}, 32'h0);
        if_pc_i = 32'h80; pred_dir_i = 1'b1;
        #3;
        chk("midrst_npc_80", npc_pred_o, 32'h84);
        if_pc_i = 32'h40;
        #1;
        chk("midrst_npc_40", npc_pred_o, 32'h44);
        chk("midrst_ptaken", {31'b0, pred_taken_o}, 32'h0);
        @(posedge CLK); #1;

        // Drive miss_cnt to all-ones, then one more mispredict must not wrap
        drive(mk(32'h0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0,
                 32'h0, 1'b0, 1'b0, 32'h0));
        repeat (65535) @(posedge CLK);
        #1;
        chk("sat_reach", {16'b0, miss_cnt_o}, 32'hFFFF);
        @(posedge CLK); #1;
        chk("sat_hold", {16'b0, miss_cnt_o}, 32'hFFFF);
        chk("sat_hit_idle", {16'b0, hit_cnt_o}, 32'h0);
        idle();
        if_pc_i = 32'hFFFFFFFC; pred_dir_i = 1'b1;
        #3;
        chk("wrap_npc", npc_pred_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
